// File: rtl/mul8_seq_ctrl_if.sv
// mul8_seq_ctrl_if: operand handshake and shared-multiplier port bundle
interface mul8_seq_ctrl_if;
   logic        start;
   logic        sgn;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [3:0]  mul_in0;
   logic [3:0]  mul_in1;
   logic [7:0]  mul_out;
   modport slave (
      input  start, sgn, a, b, mul_out,
      output busy, done, product, mul_in0, mul_in1
   );
   modport master (
      output start, sgn, a, b, mul_out,
      input  busy, done, product, mul_in0, mul_in1
   );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 multiply sequenced over four passes of a shared 4x4 multiplier
module mul8_seq_ctrl (
   input  logic           clk,
   input  logic           rst,
   mul8_seq_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;
   logic [1:0]  r_state;
   logic [1:0]  r_step;
   logic [7:0]  r_ra;
   logic [7:0]  r_rb;
   logic        r_neg;
   logic [15:0] r_acc;
   logic [15:0] r_product;
   logic        w_calc;
   logic [3:0]  w_shift;
   logic [15:0] w_sum;
   logic [7:0]  w_mag_a;
   logic [7:0]  w_mag_b;
   always_comb begin
      w_calc  = r_state == S_CALC;
      w_shift = r_step == 2'd0 ? 4'd0 : r_step == 2'd3 ? 4'd8 : 4'd4;
      w_sum   = r_acc + ({8'd0, bus.mul_out} << w_shift);
      w_mag_a = (bus.sgn && bus.a[7]) ? 8'd0 - bus.a : bus.a;
      w_mag_b = (bus.sgn && bus.b[7]) ? 8'd0 - bus.b : bus.b;
   end
   assign bus.busy    = w_calc;
   assign bus.done    = r_state == S_DONE;
   assign bus.product = r_product;
   assign bus.mul_in0 = w_calc ? (r_step[0] ? r_ra[7:4] : r_ra[3:0]) : 4'd0;
   assign bus.mul_in1 = w_calc ? (r_step[1] ? r_rb[7:4] : r_rb[3:0]) : 4'd0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_step    <= 2'd0;
         r_ra      <= 8'd0;
         r_rb      <= 8'd0;
         r_neg     <= 1'b0;
         r_acc     <= 16'd0;
         r_product <= 16'd0;
      end else if (w_calc) begin
         r_acc  <= w_sum;
         r_step <= r_step + 2'd1;
         if (r_step == 2'd3) begin
            r_product <= r_neg ? ~w_sum + 16'd1 : w_sum;
            r_state   <= S_DONE;
         end
      end else if (bus.start) begin
         r_ra    <= w_mag_a;
         r_rb    <= w_mag_b;
         r_neg   <= bus.sgn & (bus.a[7] ^ bus.b[7]);
         r_acc   <= 16'd0;
         r_step  <= 2'd0;
         r_state <= S_CALC;
      end else begin
         r_state <= S_IDLE;
      end
   end
endmodule
